ex_mem_stall: RTL and testbench
===============================

EX_MEM_STALL -- requirements
Module: ex_mem_stall

Interface
REQ-001 The block SHALL have parameter DW, default 32, data and HI/LO width.
REQ-002 The block SHALL have parameter AW, default 5, register-file write-address width.
REQ-003 The block SHALL have parameter CW, default 2, multi-cycle-op counter width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-006 The block SHALL have port rst_, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port stall_ex, input, 1, EX stage stalled this cycle.
REQ-008 The block SHALL have port stall_mem, input, 1, MEM stage stalled this cycle.
REQ-009 The block SHALL have port flush, input, 1, squash the stage contents.
REQ-010 The block SHALL have ports ex_o_valid (1), ex_o_wreg (1), ex_o_waddr (AW), ex_o_wdata (DW), all inputs, EX-stage GPR write request.
REQ-011 The block SHALL have ports ex_o_we_hilo (1), ex_o_wdata_hi (DW), ex_o_wdata_lo (DW), all inputs, EX-stage HI/LO write request.
REQ-012 The block SHALL have ports ex_o_hilo_tmp (2*DW) and ex_o_cnt (CW), both inputs, partial result and step count of a multi-cycle op.
REQ-013 The block SHALL have outputs mem_i_valid, mem_i_wreg, mem_i_waddr, mem_i_wdata, mem_i_we_hilo, mem_i_wdata_hi and mem_i_wdata_lo, each registered and of the same width as its ex_o_ counterpart.
REQ-014 The block SHALL have outputs ex_i_hilo_tmp (2*DW) and ex_i_cnt (CW), both registered, fed back to EX.

Function
REQ-015 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-016 Each rising edge SHALL apply exactly one action, chosen in priority order: reset > flush > bubble > load > hold.
REQ-017 Flush (flush=1) SHALL clear every output to 0, including ex_i_cnt and ex_i_hilo_tmp, regardless of the stall inputs.
REQ-018 Bubble (stall_ex=1, stall_mem=0) SHALL clear all mem_i_* outputs to 0.
REQ-019 Bubble SHALL capture ex_o_hilo_tmp into ex_i_hilo_tmp and ex_o_cnt into ex_i_cnt.
REQ-020 Load (stall_ex=0) SHALL copy every ex_o_* GPR/HI-LO/valid input to its mem_i_* output.
REQ-021 Load SHALL clear ex_i_cnt and ex_i_hilo_tmp to 0.
REQ-022 Hold (stall_ex=1, stall_mem=1) SHALL keep every output at its previous value.
REQ-023 stall_mem=1 with stall_ex=0 SHALL be treated as load; MEM-stall consistency is the stall controller's responsibility.
REQ-024 Latency from EX input to MEM output SHALL be exactly one clock for a load.
REQ-025 ex_i_cnt SHALL be a plain register: no increment and no wrap inside the block; EX owns counting.
REQ-026 When mem_i_valid=0, the mem_i_wreg and mem_i_we_hilo outputs SHALL be 0 after bubble, flush or reset.
REQ-027 A load with ex_o_valid=0 SHALL be passed through verbatim, with no gating of write enables.
REQ-028 Back-to-back bubbles SHALL each recapture hilo_tmp and cnt, so the last value wins.
REQ-029 The stall inputs SHALL be sampled only at the clock edge and SHALL not be treated as level-latched.

Reset
REQ-030 rst_=0 at a rising edge SHALL set every output to 0, overriding flush and stall.
REQ-031 Reset asserted mid multi-cycle op SHALL discard ex_i_cnt and ex_i_hilo_tmp.
REQ-032 The first edge after rst_ returns to 1 SHALL perform normal action selection.
REQ-033 There SHALL be no asynchronous behaviour: rst_ changing between edges SHALL have no effect.

Verification
REQ-034 Scenario 1 (load/latency): stall_ex=stall_mem=flush=0, ex_o_wreg=1, waddr=5'h1F, wdata=32'hDEADBEEF, valid=1 -> next cycle mem_i_* equal these values; ex_i_cnt=0.
REQ-035 Scenario 2 (madd bubble): stall_ex=1, stall_mem=0, ex_o_cnt=2'b01, ex_o_hilo_tmp=64'h0000_0001_0000_0002 -> mem_i_* all 0, ex_i_cnt=1, ex_i_hilo_tmp=64'h0000_0001_0000_0002; next cycle stall_ex=0 with new ex_o_* data -> ex_i_cnt=0 and mem_i_* equal the new data.
REQ-036 Scenario 3 (hold): load wdata=32'h12345678, then stall_ex=stall_mem=1 for 3 cycles while ex_o_wdata changes every cycle -> mem_i_wdata stays 32'h12345678 for all 3 cycles.
REQ-037 Scenario 4 (flush priority): flush=1 with stall_ex=1, stall_mem=1 and nonzero ex_i_cnt -> all outputs 0 on next edge.
REQ-038 Scenario 5 (reset): rst_=0 together with flush=1 and a load of nonzero data -> all outputs 0; rst_ pulsed low between clock edges only -> outputs unchanged.
REQ-039 Scenario 6 (parameters): instantiate with DW=64, AW=6, CW=3 and repeat Scenarios 1-2 with full-width all-ones values -> exact bit-for-bit propagation on every output.

Source files
------------

// File: rtl/ex_mem_stall.sv
// EX/MEM pipeline register with stall, bubble and flush handling, plus the
// feedback path that carries a multi-cycle op's partial result back into EX.
module ex_mem_stall #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 2
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            stall_ex,
  input  logic            stall_mem,
  input  logic            flush,

  input  logic            ex_o_valid,
  input  logic            ex_o_wreg,
  input  logic [AW-1:0]   ex_o_waddr,
  input  logic [DW-1:0]   ex_o_wdata,
  input  logic            ex_o_we_hilo,
  input  logic [DW-1:0]   ex_o_wdata_hi,
  input  logic [DW-1:0]   ex_o_wdata_lo,
  input  logic [2*DW-1:0] ex_o_hilo_tmp,
  input  logic [CW-1:0]   ex_o_cnt,

  output logic            mem_i_valid,
  output logic            mem_i_wreg,
  output logic [AW-1:0]   mem_i_waddr,
  output logic [DW-1:0]   mem_i_wdata,
  output logic            mem_i_we_hilo,
  output logic [DW-1:0]   mem_i_wdata_hi,
  output logic [DW-1:0]   mem_i_wdata_lo,
  output logic [2*DW-1:0] ex_i_hilo_tmp,
  output logic [CW-1:0]   ex_i_cnt
);

  // Action priority: reset > flush > bubble > load > hold. Hold is simply the
  // absence of an assignment, so every output keeps its value.
  // NOTE: non-blocking assignments keep every register sampling the pre-edge
  // value of its inputs, which is what makes this a true pipeline stage.
  always_ff @(posedge clk) begin
    if (!rst_ || flush) begin
      mem_i_valid    <= 1'b0;
      mem_i_wreg     <= 1'b0;
      mem_i_waddr    <= '0;
      mem_i_wdata    <= '0;
      mem_i_we_hilo  <= 1'b0;
      mem_i_wdata_hi <= '0;
      mem_i_wdata_lo <= '0;
      ex_i_hilo_tmp  <= '0;
      ex_i_cnt       <= '0;
    end else if (!stall_ex) begin
      // Load: MEM stall without EX stall is the stall controller's problem,
      // so it is deliberately treated the same as a plain load.
      mem_i_valid    <= ex_o_valid;
      mem_i_wreg     <= ex_o_wreg;
      mem_i_waddr    <= ex_o_waddr;
      mem_i_wdata    <= ex_o_wdata;
      mem_i_we_hilo  <= ex_o_we_hilo;
      mem_i_wdata_hi <= ex_o_wdata_hi;
      mem_i_wdata_lo <= ex_o_wdata_lo;
      ex_i_hilo_tmp  <= '0;
      ex_i_cnt       <= '0;
    end else if (!stall_mem) begin
      // Bubble: MEM sees a NOP while EX's partial result loops back.
      mem_i_valid    <= 1'b0;
      mem_i_wreg     <= 1'b0;
      mem_i_waddr    <= '0;
      mem_i_wdata    <= '0;
      mem_i_we_hilo  <= 1'b0;
      mem_i_wdata_hi <= '0;
      mem_i_wdata_lo <= '0;
      ex_i_hilo_tmp  <= ex_o_hilo_tmp;
      ex_i_cnt       <= ex_o_cnt;
    end
  end

endmodule

// File: tb/tb_ex_mem_stall.sv
// Bench for ex_mem_stall: a default-width and a wide instance share one
// stimulus stream and are compared every cycle against a rule-level model.
module tb_ex_mem_stall;

  typedef struct packed {
    logic         valid;
    logic         wreg;
    logic [5:0]   waddr;
    logic [63:0]  wdata;
    logic         we_hilo;
    logic [63:0]  hi;
    logic [63:0]  lo;
    logic [127:0] hilo_tmp;
    logic [2:0]   cnt;
  } st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_, stall_ex, stall_mem, flush;
  logic         in_valid, in_wreg, in_we_hilo;
  logic [5:0]   in_waddr;
  logic [63:0]  in_wdata, in_hi, in_lo;
  logic [127:0] in_hilo;
  logic [2:0]   in_cnt;

  logic         n_valid, n_wreg, n_we_hilo;
  logic [4:0]   n_waddr;
  logic [31:0]  n_wdata, n_hi, n_lo;
  logic [63:0]  n_hilo;
  logic [1:0]   n_cnt;

  logic         w_valid, w_wreg, w_we_hilo;
  logic [5:0]   w_waddr;
  logic [63:0]  w_wdata, w_hi, w_lo;
  logic [127:0] w_hilo;
  logic [2:0]   w_cnt;

  ex_mem_stall u_narrow (
    .clk(clk), .rst_(rst_), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_o_valid(in_valid), .ex_o_wreg(in_wreg), .ex_o_waddr(in_waddr[4:0]),
    .ex_o_wdata(in_wdata[31:0]), .ex_o_we_hilo(in_we_hilo),
    .ex_o_wdata_hi(in_hi[31:0]), .ex_o_wdata_lo(in_lo[31:0]),
    .ex_o_hilo_tmp(in_hilo[63:0]), .ex_o_cnt(in_cnt[1:0]),
    .mem_i_valid(n_valid), .mem_i_wreg(n_wreg), .mem_i_waddr(n_waddr),
    .mem_i_wdata(n_wdata), .mem_i_we_hilo(n_we_hilo),
    .mem_i_wdata_hi(n_hi), .mem_i_wdata_lo(n_lo),
    .ex_i_hilo_tmp(n_hilo), .ex_i_cnt(n_cnt)
  );

  ex_mem_stall #(.DW(64), .AW(6), .CW(3)) u_wide (
    .clk(clk), .rst_(rst_), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_o_valid(in_valid), .ex_o_wreg(in_wreg), .ex_o_waddr(in_waddr),
    .ex_o_wdata(in_wdata), .ex_o_we_hilo(in_we_hilo),
    .ex_o_wdata_hi(in_hi), .ex_o_wdata_lo(in_lo),
    .ex_o_hilo_tmp(in_hilo), .ex_o_cnt(in_cnt),
    .mem_i_valid(w_valid), .mem_i_wreg(w_wreg), .mem_i_waddr(w_waddr),
    .mem_i_wdata(w_wdata), .mem_i_we_hilo(w_we_hilo),
    .mem_i_wdata_hi(w_hi), .mem_i_wdata_lo(w_lo),
    .ex_i_hilo_tmp(w_hilo), .ex_i_cnt(w_cnt)
  );

  st_t act_n, act_w;
  assign act_n = {n_valid, n_wreg, 1'b0, n_waddr, 32'b0, n_wdata, n_we_hilo,
                  32'b0, n_hi, 32'b0, n_lo, 64'b0, n_hilo, 1'b0, n_cnt};
  assign act_w = {w_valid, w_wreg, w_waddr, w_wdata, w_we_hilo,
                  w_hi, w_lo, w_hilo, w_cnt};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [331:0] act, input logic [331:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // What the default-width instance must show: the same rules on truncated data.
  function automatic st_t narrow(input st_t s);
    st_t r = s;
    r.waddr[5]          = 1'b0;
    r.wdata[63:32]      = '0;
    r.hi[63:32]         = '0;
    r.lo[63:32]         = '0;
    r.hilo_tmp[127:64]  = '0;
    r.cnt[2]            = 1'b0;
    return r;
  endfunction

  // Reference model: the MEM view is either cleared, a copy of the EX request,
  // or unchanged; the feedback view is either cleared, captured, or unchanged.
  st_t exp_m = '0;
  always @(posedge clk) begin
    st_t req;
    req = '{valid: in_valid, wreg: in_wreg, waddr: in_waddr, wdata: in_wdata,
            we_hilo: in_we_hilo, hi: in_hi, lo: in_lo, hilo_tmp: '0, cnt: '0};
    if (rst_ !== 1'b1 || flush)      exp_m = '0;
    else if (!stall_ex)              exp_m = req;
    else if (!stall_mem) begin
      exp_m          = '0;
      exp_m.hilo_tmp = in_hilo;
      exp_m.cnt      = in_cnt;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_wide", act_w, exp_m);
      check("model_narrow", act_n, narrow(exp_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ctl(input logic r, input logic f, input logic se, input logic sm);
    rst_ = r; flush = f; stall_ex = se; stall_mem = sm;
  endtask

  task automatic set_req(input logic v, input logic wr, input logic [5:0] a,
                         input logic [63:0] d, input logic wh, input logic [63:0] hi,
                         input logic [63:0] lo);
    in_valid = v; in_wreg = wr; in_waddr = a; in_wdata = d;
    in_we_hilo = wh; in_hi = hi; in_lo = lo;
  endtask

  task automatic randomize_req();
    set_req(1'($urandom), 1'($urandom), 6'($urandom), {$urandom, $urandom},
            1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    in_hilo = {$urandom, $urandom, $urandom, $urandom};
    in_cnt  = 3'($urandom);
  endtask

  initial begin
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    set_req(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    in_hilo = '0; in_cnt = '0;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_state", act_w, 332'd0);

    // Load and one-cycle latency
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_req(1'b1, 1'b1, 6'h1F, 64'hDEADBEEF, 1'b0, 64'h0, 64'h0);
    tick();
    check("s1_wdata", {300'd0, n_wdata}, {300'd0, 32'hDEADBEEF});
    check("s1_waddr", {327'd0, n_waddr}, {327'd0, 5'h1F});
    check("s1_cnt", {330'd0, n_cnt}, 332'd0);

    // Multi-cycle op bubble, then release with new data
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
    in_cnt = 3'b001; in_hilo = 128'h0000_0001_0000_0002;
    tick();
    check("s2_mem_valid", {331'd0, n_valid}, 332'd0);
    check("s2_cnt", {330'd0, n_cnt}, 332'd1);
    check("s2_hilo", {268'd0, n_hilo}, {268'd0, 64'h0000_0001_0000_0002});
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_req(1'b1, 1'b0, 6'h03, 64'hCAFEF00D, 1'b1, 64'h1111, 64'h2222);
    tick();
    check("s2_release_cnt", {330'd0, n_cnt}, 332'd0);
    check("s2_release_wdata", {300'd0, n_wdata}, {300'd0, 32'hCAFEF00D});

    // Hold for three cycles with moving EX data
    set_req(1'b1, 1'b1, 6'h07, 64'h12345678, 1'b0, 64'h0, 64'h0);
    tick();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_wdata = {$urandom, $urandom};
      tick();
      check("s3_hold_wdata", {300'd0, n_wdata}, {300'd0, 32'h12345678});
    end

    // Flush overrides a full stall with live feedback state
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
    in_cnt = 3'b010; in_hilo = 128'hABCD;
    tick();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("s4_flush_all", act_n, 332'd0);

    // Reset overrides flush and a load; a between-edge pulse does nothing
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_req(1'b1, 1'b1, 6'h0A, 64'h55AA55AA, 1'b1, 64'h1, 64'h2);
    tick();
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("s5_reset_all", act_n, 332'd0);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
    #1 rst_ = 1'b0;
    #2 rst_ = 1'b1;
    tick();
    check("s5_glitch_wdata", {300'd0, n_wdata}, {300'd0, 32'h55AA55AA});

    // Full-width all-ones propagation on the wide instance
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_req(1'b1, 1'b1, 6'h3F, '1, 1'b1, '1, '1);
    tick();
    check("s6_load_ones", act_w, {2'b11, 6'h3F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                                  {128{1'b1}}, 128'd0, 3'd0});
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
    in_hilo = '1; in_cnt = '1;
    tick();
    check("s6_bubble_ones", act_w, {204'd0, {128{1'b1}}} << 3 | 332'd7);

    // Random traffic, including back-to-back bubbles and between-edge glitches
    for (int i = 0; i < 600; i++) begin
      randomize_req();
      set_ctl(($urandom_range(31) != 0), ($urandom_range(7) == 0),
              1'($urandom), 1'($urandom));
      if (rst_ && $urandom_range(15) == 0) begin
        #1 rst_ = 1'b0;
        #1 rst_ = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
